// File: rtl/cnn_pkg.sv
// Shared widths, types and the requantisation helper for the 3x3 convolution PE.
package cnn_pkg;

  localparam int CNN_DATA_W = 8;
  localparam int CNN_WGT_W  = 8;
  localparam int CNN_BIAS_W = 16;
  localparam int CNN_ACC_W  = 24;
  localparam int CNN_SHIFT  = 4;
  localparam int CNN_TAPS   = 9;

  typedef logic        [CNN_DATA_W-1:0] pixel_t;
  typedef logic signed [CNN_WGT_W-1:0]  weight_t;
  typedef logic signed [CNN_ACC_W-1:0]  acc_t;
  typedef weight_t                      kernel_t [CNN_TAPS];

  localparam acc_t PIX_MAX = acc_t'((1 << CNN_DATA_W) - 1);

  // ReLU, arithmetic right shift with truncation, then clamp to the pixel range.
  function automatic pixel_t requant(input acc_t acc, input int unsigned shift);
    acc_t   shifted;
    pixel_t result;
    shifted = acc >>> shift;
    if (acc[CNN_ACC_W-1])
      result = '0;
    else if (shifted > PIX_MAX)
      result = '1;
    else
      result = shifted[CNN_DATA_W-1:0];
    return result;
  endfunction

endpackage

// File: rtl/kernel_bank.sv
// Kernel storage: serial shadow load, atomic commit to the active bank on the 9th write.
module kernel_bank #(
  parameter int WGT_W  = 8,
  parameter int BIAS_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wgt_wr,
  input  logic signed [WGT_W-1:0]  wgt_in,
  input  logic signed [BIAS_W-1:0] bias_in,
  output logic signed [WGT_W-1:0]  kernel [9],
  output logic signed [BIAS_W-1:0] bias,
  output logic                     kernel_ready
);

  logic signed [WGT_W-1:0] shadow [9];
  logic [3:0]              cnt;

  // Shadow fill and commit; the last weight goes straight into the active bank
  // because it is not yet visible in the shadow registers on the commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow       <= '{default: '0};
      kernel       <= '{default: '0};
      bias         <= '0;
      cnt          <= '0;
      kernel_ready <= 1'b0;
    end else if (wgt_wr) begin
      shadow[cnt] <= wgt_in;
      if (cnt == 4'd8) begin
        for (int i = 0; i < 8; i++) kernel[i] <= shadow[i];
        kernel[8]    <= wgt_in;
        bias         <= bias_in;
        cnt          <= '0;
        kernel_ready <= 1'b1;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/conv3x3_pe.sv
// Pipelined 3x3 convolution PE: multiply, row sums, bias add, requantise.
module conv3x3_pe
  import cnn_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int WGT_W  = CNN_WGT_W,
  parameter int BIAS_W = CNN_BIAS_W,
  parameter int ACC_W  = CNN_ACC_W,
  parameter int SHIFT  = CNN_SHIFT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [DATA_W-1:0]        w00,
  input  logic [DATA_W-1:0]        w01,
  input  logic [DATA_W-1:0]        w02,
  input  logic [DATA_W-1:0]        w10,
  input  logic [DATA_W-1:0]        w11,
  input  logic [DATA_W-1:0]        w12,
  input  logic [DATA_W-1:0]        w20,
  input  logic [DATA_W-1:0]        w21,
  input  logic [DATA_W-1:0]        w22,
  input  logic                     window_valid,
  input  logic                     wgt_wr,
  input  logic signed [WGT_W-1:0]  wgt_in,
  input  logic signed [BIAS_W-1:0] bias_in,
  output logic                     kernel_ready,
  output logic [DATA_W-1:0]        pix_out,
  output logic                     out_valid
);

  localparam int PROD_W = DATA_W + WGT_W + 1;
  localparam int ROW_W  = PROD_W + 2;

  logic [DATA_W-1:0]        tap [9];
  logic signed [WGT_W-1:0]  kern [9];
  logic signed [BIAS_W-1:0] kbias;

  logic signed [PROD_W-1:0] prod [9];
  logic signed [BIAS_W-1:0] bias1;
  logic                     v1;

  logic signed [ROW_W-1:0]  row [3];
  logic signed [BIAS_W-1:0] bias2;
  logic                     v2;

  logic signed [ACC_W-1:0]  acc3;
  logic                     v3;

  logic [DATA_W-1:0]        req_pix;

  assign tap = '{w00, w01, w02, w10, w11, w12, w20, w21, w22};

  kernel_bank #(
    .WGT_W  (WGT_W),
    .BIAS_W (BIAS_W)
  ) u_kernel_bank (
    .clk          (clk),
    .rst_n        (rst_n),
    .wgt_wr       (wgt_wr),
    .wgt_in       (wgt_in),
    .bias_in      (bias_in),
    .kernel       (kern),
    .bias         (kbias),
    .kernel_ready (kernel_ready)
  );

  // S1: products against the active bank; bias travels with the window so a
  // kernel swap never mixes old weights with a new bias.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod  <= '{default: '0};
      bias1 <= '0;
      v1    <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < 9; i++)
        prod[i] <= PROD_W'(signed'({1'b0, tap[i]})) * PROD_W'(kern[i]);
      bias1 <= kbias;
      v1    <= window_valid & kernel_ready;
    end
  end

  // S2: one sum per kernel row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row   <= '{default: '0};
      bias2 <= '0;
      v2    <= 1'b0;
    end else if (en) begin
      for (int r = 0; r < 3; r++)
        row[r] <= ROW_W'(prod[3*r]) + ROW_W'(prod[3*r+1]) + ROW_W'(prod[3*r+2]);
      bias2 <= bias1;
      v2    <= v1;
    end
  end

  // S3: total of the rows plus sign-extended bias.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc3 <= '0;
      v3   <= 1'b0;
    end else if (en) begin
      acc3 <= ACC_W'(row[0]) + ACC_W'(row[1]) + ACC_W'(row[2]) + ACC_W'(bias2);
      v3   <= v2;
    end
  end

  // Requantisation: shared package helper at default widths, local equivalent otherwise.
  if (ACC_W == CNN_ACC_W && DATA_W == CNN_DATA_W) begin : g_pkg_requant
    always_comb req_pix = requant(acc3, SHIFT);
  end else begin : g_local_requant
    localparam logic signed [ACC_W-1:0] LOCAL_MAX = ACC_W'((1 << DATA_W) - 1);
    logic signed [ACC_W-1:0] shifted;
    always_comb begin
      shifted = acc3 >>> SHIFT;
      if (acc3[ACC_W-1])
        req_pix = '0;
      else if (shifted > LOCAL_MAX)
        req_pix = '1;
      else
        req_pix = shifted[DATA_W-1:0];
    end
  end

  // S4: registered output; pix_out only updates for valid results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_out   <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= v3;
      if (v3) pix_out <= req_pix;
    end
  end

endmodule

// File: tb/tb_conv3x3_pe.sv
// Scoreboard bench for conv3x3_pe with a plain-arithmetic reference model.
module tb_conv3x3_pe;

  localparam int SHIFT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              window_valid = 1'b0;
  logic              wgt_wr = 1'b0;
  logic [7:0]        tap [9];
  logic signed [7:0] wgt_in = '0;
  logic signed [15:0] bias_in = '0;
  logic              kernel_ready;
  logic [7:0]        pix_out;
  logic              out_valid;

  always #5 clk = ~clk;

  conv3x3_pe #(
    .DATA_W (8), .WGT_W (8), .BIAS_W (16), .ACC_W (24), .SHIFT (SHIFT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .w00          (tap[0]), .w01 (tap[1]), .w02 (tap[2]),
    .w10          (tap[3]), .w11 (tap[4]), .w12 (tap[5]),
    .w20          (tap[6]), .w21 (tap[7]), .w22 (tap[8]),
    .window_valid (window_valid),
    .wgt_wr       (wgt_wr),
    .wgt_in       (wgt_in),
    .bias_in      (bias_in),
    .kernel_ready (kernel_ready),
    .pix_out      (pix_out),
    .out_valid    (out_valid)
  );

  int errors = 0;
  int checks = 0;

  typedef struct { int pix; int due; } exp_t;
  exp_t sb [$];

  // Reference model state: what the kernel loader should hold.
  int m_shadow [9];
  int m_active [9];
  int m_bias;
  int m_cnt;
  bit m_ready;

  int ecnt = 0;
  bit en_last = 1'b0;

  always @(posedge clk) begin
    en_last = en && rst_n;
    if (en && rst_n) ecnt++;
  end

  function automatic int ref_pix();
    int s;
    s = m_bias;
    for (int i = 0; i < 9; i++) s += int'(tap[i]) * m_active[i];
    if (s < 0) return 0;
    s = s >> SHIFT;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a fresh result appears after every enabled edge with out_valid set.
  always @(negedge clk) begin
    if (rst_n && en_last && out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got pix=%0d expected none at %0t", pix_out, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (pix_out !== 8'(e.pix) || ecnt != e.due) begin
          errors++;
          $display("FAIL pix_out: got %0d at cycle %0d expected %0d at cycle %0d",
                   pix_out, ecnt, e.pix, e.due);
        end
      end
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < 9; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    m_bias  = 0;
    m_cnt   = 0;
    m_ready = 1'b0;
  endfunction

  // One cycle with whatever is on the pins: predict, then clock.
  task automatic step();
    chk("kernel_ready", int'(kernel_ready), int'(m_ready));
    if (en && window_valid && m_ready) sb.push_back('{pix: ref_pix(), due: ecnt + 4});
    if (wgt_wr) begin
      m_shadow[m_cnt] = int'(wgt_in);
      if (m_cnt == 8) begin
        m_active = m_shadow;
        m_bias   = int'(bias_in);
        m_ready  = 1'b1;
        m_cnt    = 0;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    en = 1'b1; window_valid = 1'b0; wgt_wr = 1'b0;
    repeat (n) step();
  endtask

  task automatic set_const(input int v);
    for (int i = 0; i < 9; i++) tap[i] = 8'(v);
  endtask

  task automatic set_ramp(input int r, input int c);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) tap[i*3+j] = 8'((r + i) * 5 + (c + j));
  endtask

  task automatic send_window();
    en = 1'b1; window_valid = 1'b1; wgt_wr = 1'b0;
    step();
    window_valid = 1'b0;
  endtask

  task automatic write_wgt(input int w, input int b, input bit with_window);
    en = 1'b1; wgt_wr = 1'b1; wgt_in = 8'(w); bias_in = 16'(b);
    window_valid = with_window;
    step();
    wgt_wr = 1'b0; window_valid = 1'b0;
  endtask

  task automatic load(input int k [9], input int b);
    for (int i = 0; i < 9; i++) write_wgt(k[i], b, 1'b0);
  endtask

  int k_ident [9] = '{0, 0, 0, 0, 16, 0, 0, 0, 0};
  int k_dbl   [9] = '{0, 0, 0, 0, 32, 0, 0, 0, 0};
  int k_ones  [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
  int k_neg   [9] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};
  int k_rand  [9];

  initial begin
    model_reset();
    set_const(0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_pix_out", int'(pix_out), 0);
    chk("reset_kernel_ready", int'(kernel_ready), 0);
    rst_n = 1'b1;

    // windows with no kernel are dropped
    for (int i = 0; i < 4; i++) begin
      set_const($urandom_range(0, 255));
      send_window();
    end

    // identity kernel (scaled by 2^SHIFT), window on the commit edge is still dropped
    for (int i = 0; i < 8; i++) write_wgt(k_ident[i], 0, 1'b0);
    write_wgt(k_ident[8], 0, 1'b1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        set_ramp(r, c);
        send_window();
      end
    idle(5);

    // saturation and ReLU corners
    load(k_ones, 0);
    set_const(255); send_window();
    load(k_ones, 4000);
    set_const(255); send_window();
    load(k_neg, 0);
    set_const(10); send_window();
    idle(5);

    // swap with windows in flight; partial load must not disturb the active bank
    load(k_ident, 0);
    for (int i = 0; i < 8; i++) write_wgt(k_dbl[i], 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_const(20 + i); send_window();
    end
    set_const(30);
    write_wgt(k_dbl[8], 0, 1'b1);
    set_const(40); send_window();
    set_const(50); send_window();

    // stall for three cycles mid-stream, with weight writes during the stall
    for (int i = 0; i < 10; i++) begin
      set_ramp(i % 3, (i / 3) % 3);
      window_valid = 1'b1; wgt_wr = 1'b0;
      en = !(i >= 4 && i < 7);
      if (i == 5) begin wgt_wr = 1'b1; wgt_in = 8'sd3; end
      step();
    end
    window_valid = 1'b0; wgt_wr = 1'b0;
    idle(6);

    // random traffic with random kernel reloads
    for (int n = 0; n < 400; n++) begin
      en           = ($urandom_range(0, 9) != 0);
      window_valid = $urandom_range(0, 3) != 0;
      wgt_wr       = ($urandom_range(0, 4) == 0);
      wgt_in       = 8'($urandom);
      bias_in      = 16'($urandom_range(0, 8000)) - 16'sd4000;
      for (int i = 0; i < 9; i++) tap[i] = 8'($urandom);
      step();
    end
    wgt_wr = 1'b0;

    // reset with a full pipeline
    for (int i = 0; i < 9; i++) k_rand[i] = $urandom_range(0, 40) - 20;
    load(k_rand, 500);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 9; j++) tap[j] = 8'($urandom);
      send_window();
    end
    chk("pre_reset_out_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", int'(out_valid), 0);
    chk("async_reset_pix_out", int'(pix_out), 0);
    chk("async_reset_kernel_ready", int'(kernel_ready), 0);
    sb.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_const(100); send_window();
    end
    for (int i = 0; i < 9; i++) k_rand[i] = $urandom_range(0, 60) - 30;
    load(k_rand, -200);
    for (int n = 0; n < 30; n++) begin
      en           = ($urandom_range(0, 5) != 0);
      window_valid = $urandom_range(0, 1);
      for (int i = 0; i < 9; i++) tap[i] = 8'($urandom);
      step();
    end
    idle(8);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 1ms");
    $fatal(1, "watchdog");
  end

endmodule
